// File: rtl/fsm_pattern_if.sv
// Bundle of the serial-detector signals so a bench or a parent block can pass
// them around as one object; clk and reset stay outside the bundle.
interface fsm_pattern_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic [2:0]       state_o;

  modport master (output din, input  y, match_count, state_o);
  modport slave  (input  din, output y, match_count, state_o);
endinterface

// File: rtl/fsm_pattern.sv
// Moore detector for the serial pattern 1-0-1-0 (oldest bit first), with a
// saturating detection counter and a debug view of the state register.
module fsm_pattern #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             din,
  input  logic             reset,
  input  logic             clk,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             y_reg;
  logic [CNT_W-1:0] count_reg;

  always_comb begin
    state_next = S0;
    case (state_reg)
      S0: state_next = din ? S1 : S0;
      S1: state_next = din ? S1 : S2;
      S2: state_next = din ? S3 : S0;
      S3: state_next = din ? S1 : S4;
      // Overlapping mode keeps the trailing "10" so a following "10" detects again.
      S4: begin
        if (OVERLAP != 0) state_next = din ? S3 : S0;
        else              state_next = din ? S1 : S0;
      end
      default: state_next = S0;
    endcase
  end

  // y is registered from the next state, so it always equals (state_reg == S4).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S0;
      y_reg     <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      y_reg     <= (state_next == S4);
      if (state_next == S4 && count_reg != {CNT_W{1'b1}})
        count_reg <= count_reg + 1'b1;
    end
  end

  assign y           = y_reg;
  assign match_count = count_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_fsm_pattern.sv
// Bench for fsm_pattern: three instances (overlapping, non-overlapping, 2-bit
// counter) share one serial stream; a suffix-window model feeds a scoreboard.
module tb_fsm_pattern;

  logic clk;
  logic reset;

  fsm_pattern_if #(.CNT_W(8)) if_ov  ();
  fsm_pattern_if #(.CNT_W(8)) if_nov ();
  fsm_pattern_if #(.CNT_W(2)) if_sat ();

  fsm_pattern #(.OVERLAP(1), .CNT_W(8)) u_ov (
    .din(if_ov.din), .reset(reset), .clk(clk),
    .y(if_ov.y), .match_count(if_ov.match_count), .state_o(if_ov.state_o));

  fsm_pattern #(.OVERLAP(0), .CNT_W(8)) u_nov (
    .din(if_nov.din), .reset(reset), .clk(clk),
    .y(if_nov.y), .match_count(if_nov.match_count), .state_o(if_nov.state_o));

  fsm_pattern #(.OVERLAP(1), .CNT_W(2)) u_sat (
    .din(if_sat.din), .reset(reset), .clk(clk),
    .y(if_sat.y), .match_count(if_sat.match_count), .state_o(if_sat.state_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   dut;
    logic y;
    int   st;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];

  int       checks   = 0;
  int       failures = 0;
  int       hlen [3];
  int       hist [3];
  int       cnt  [3];
  int       cmax [3];
  bit       ov   [3];
  string    names[3];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int obs_y(input int i);
    case (i)
      0: return int'(if_ov.y);
      1: return int'(if_nov.y);
      default: return int'(if_sat.y);
    endcase
  endfunction

  function automatic int obs_st(input int i);
    case (i)
      0: return int'(if_ov.state_o);
      1: return int'(if_nov.state_o);
      default: return int'(if_sat.state_o);
    endcase
  endfunction

  function automatic int obs_cnt(input int i);
    case (i)
      0: return int'(if_ov.match_count);
      1: return int'(if_nov.match_count);
      default: return int'(if_sat.match_count);
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) begin
      hlen[i] = 0;
      hist[i] = 0;
      cnt[i]  = 0;
    end
  endfunction

  // State = detect, else the longest suffix of the history that is a prefix of 1010.
  function automatic exp_t model_step(input int i, input bit b);
    exp_t e;
    e.dut = i;
    e.y   = 1'b0;
    e.st  = 0;
    if (reset !== 1'b1) begin
      hlen[i] = 0; hist[i] = 0; cnt[i] = 0;
    end else begin
      hist[i] = ((hist[i] << 1) | int'(b)) & 15;
      if (hlen[i] < 4) hlen[i]++;
      if (hlen[i] == 4 && hist[i] == 10) begin
        e.y  = 1'b1;
        e.st = 4;
        if (cnt[i] < cmax[i]) cnt[i]++;
        if (!ov[i]) hlen[i] = 0;
      end else begin
        for (int k = 3; k >= 1; k--) begin
          if (e.st == 0 && hlen[i] >= k && (hist[i] & ((1 << k) - 1)) == (10 >> (4 - k)))
            e.st = k;
        end
      end
    end
    e.cnt = cnt[i];
    return e;
  endfunction

  task automatic drive_bit(input bit b);
    exp_t e;
    if_ov.din  = b;
    if_nov.din = b;
    if_sat.din = b;
    for (int i = 0; i < 3; i++) exp_q.push_back(model_step(i, b));
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("din=%0b dut=%s y=%0d st=%0d cnt=%0d", b, names[e.dut],
               obs_y(e.dut), obs_st(e.dut), obs_cnt(e.dut));
      check({names[e.dut], "_y"},   obs_y(e.dut),   int'(e.y));
      check({names[e.dut], "_st"},  obs_st(e.dut),  e.st);
      check({names[e.dut], "_cnt"}, obs_cnt(e.dut), e.cnt);
    end
  endtask

  task automatic drive_seq(input logic [31:0] bits, input int n);
    for (int j = n - 1; j >= 0; j--) drive_bit(bits[j]);
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic async_reset_check(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      check({tag, "_", names[i], "_y"},   obs_y(i),   0);
      check({tag, "_", names[i], "_st"},  obs_st(i),  0);
      check({tag, "_", names[i], "_cnt"}, obs_cnt(i), 0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    names[0] = "ov";  names[1] = "nov"; names[2] = "sat";
    ov[0] = 1; ov[1] = 0; ov[2] = 1;
    cmax[0] = 255; cmax[1] = 255; cmax[2] = 3;
    model_clear();
    reset = 1'b0;
    if_ov.din = 1'b0; if_nov.din = 1'b0; if_sat.din = 1'b0;

    // Held in reset while a full pattern streams past.
    drive_seq(32'b1010_1010, 8);

    // Single detect from reset.
    release_reset();
    drive_seq(32'b1010, 4);

    // Overlapping sequence with a false start.
    async_reset_check("rst1");
    release_reset();
    drive_seq(32'b1_0110_1010, 9);

    // Long alternating run: differs between modes, saturates the 2-bit counter.
    async_reset_check("rst2");
    release_reset();
    drive_seq(32'b10_1010, 6);
    drive_seq(32'b1010, 4);
    drive_seq(32'b1010_1010, 8);

    // Partial pattern discarded by a reset pulse.
    async_reset_check("rst3");
    release_reset();
    drive_seq(32'b101, 3);
    async_reset_check("rst4");
    release_reset();
    drive_bit(1'b0);

    // Reset while in the detect state drops y immediately.
    drive_seq(32'b1010, 4);
    async_reset_check("rst5");
    release_reset();

    for (int r = 0; r < 200; r++) drive_bit(1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end

endmodule
